// File: rtl/id_stage_if.sv
// Fetch <-> decode handshake bundle.
// Fetch (master) supplies the instruction and its PC+4; decode (slave)
// answers with the PC redirect and the PC write enable used for stalls.
interface id_stage_if;
    logic [31:0] instruction_in;
    logic [31:0] pc_plus_4_in;
    logic        pc_src_out;
    logic [31:0] pc_branch_out;
    logic        pc_write_out;

    modport master (
        output instruction_in,
        output pc_plus_4_in,
        input  pc_src_out,
        input  pc_branch_out,
        input  pc_write_out
    );

    modport slave (
        input  instruction_in,
        input  pc_plus_4_in,
        output pc_src_out,
        output pc_branch_out,
        output pc_write_out
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, 32x32 register file with WB
// bypass, control decode, branch/jump resolution, hazard stall and the
// ID/EX register.
// Optional feature macro: ID_DELAY_SLOT_EN (taken branches keep the delay
// slot instruction instead of flushing it; jal then links PC+8).
module id_stage #(
    parameter logic [31:0] RESET_REG_VAL = 32'h0,
    parameter logic [31:0] NOP_INSTR     = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    id_stage_if.slave   fetch,
    input  logic        ex_reg_write_in,
    input  logic        ex_mem_read_in,
    input  logic [4:0]  ex_write_reg_in,
    input  logic        mem_reg_write_in,
    input  logic [4:0]  mem_write_reg_in,
    input  logic        wb_reg_write_in,
    input  logic [4:0]  wb_write_reg_in,
    input  logic [31:0] wb_write_data_in,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [31:0] pc_plus_4_out,
    output logic [9:0]  ctrl_out
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2A;

    // ALU operation codes carried in ctrl_out[3:0]
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6, ALU_LUI = 4'd7;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // A source register is still being produced by an instruction in EX or MEM.
    function automatic logic result_pending(
        input logic [4:0] idx,
        input logic       exw, input logic [4:0] exr,
        input logic       mw,  input logic [4:0] mr
    );
        return (idx != 5'd0) && ((exw && exr == idx) || (mw && mr == idx));
    endfunction

    // ---- IF/ID stage (p0) ----
    logic [31:0] instr_p0;
    logic [31:0] pc_plus_4_p0;
    logic [31:0] gpr [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [31:0] rs_val, rt_val;

    assign opcode = instr_p0[31:26];
    assign rs_f   = instr_p0[25:21];
    assign rt_f   = instr_p0[20:16];
    assign rd_f   = instr_p0[15:11];
    assign funct  = instr_p0[5:0];

    // Register reads see a same-cycle WB write; $0 is hard-wired to zero.
    assign rs_val = (rs_f == 5'd0) ? 32'h0 :
                    (wb_reg_write_in && wb_write_reg_in == rs_f) ? wb_write_data_in : gpr[rs_f];
    assign rt_val = (rt_f == 5'd0) ? 32'h0 :
                    (wb_reg_write_in && wb_write_reg_in == rt_f) ? wb_write_data_in : gpr[rt_f];

    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, link;
    logic [3:0]  alu_op;
    logic [4:0]  dest;
    logic [31:0] imm_val;
    logic        is_beq, is_bne, is_jump, is_jr, rt_src;
    logic [9:0]  ctrl_val;

    // Control decode of the instruction held in IF/ID
    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        link       = 1'b0;
        alu_op     = ALU_ADD;
        dest       = 5'd0;
        imm_val    = sext16(instr_p0[15:0]);
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        rt_src     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rt_src = (funct != FN_JR);
                case (funct)
                    FN_ADD: begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin reg_write = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT: begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    FN_SLL: begin reg_write = 1'b1; alu_op = ALU_SLL; end
                    FN_SRL: begin reg_write = 1'b1; alu_op = ALU_SRL; end
                    FN_JR:  is_jr = 1'b1;
                    default: ;
                endcase
                if (reg_write) dest = rd_f;
            end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; dest = rt_f; end
            OP_ANDI: begin
                reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_AND; dest = rt_f;
                imm_val   = {16'h0, instr_p0[15:0]};
            end
            OP_ORI: begin
                reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_OR; dest = rt_f;
                imm_val   = {16'h0, instr_p0[15:0]};
            end
            OP_LUI: begin
                reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_LUI; dest = rt_f;
                imm_val   = {instr_p0[15:0], 16'h0};
            end
            OP_LW: begin
                reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
                alu_src   = 1'b1; dest = rt_f;
            end
            OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; rt_src = 1'b1; end
            OP_BEQ: begin is_beq = 1'b1; alu_op = ALU_SUB; rt_src = 1'b1; end
            OP_BNE: begin is_bne = 1'b1; alu_op = ALU_SUB; rt_src = 1'b1; end
            OP_J:   is_jump = 1'b1;
            OP_JAL: begin is_jump = 1'b1; reg_write = 1'b1; link = 1'b1; dest = 5'd31; end
            default: ;
        endcase
    end

    assign ctrl_val = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, link, alu_op};

    logic signed [31:0] br_off;
    logic        load_use, branch_hazard, stall, taken;
    logic [31:0] target, link_val;

    assign br_off = sext16(instr_p0[15:0]) <<< 2;

    assign load_use = ex_mem_read_in && (ex_write_reg_in != 5'd0) &&
                      ((ex_write_reg_in == rs_f) || (rt_src && ex_write_reg_in == rt_f));

    // Branches and jr compare/consume operands in ID, so any in-flight producer stalls them.
    assign branch_hazard =
        ((is_beq || is_bne) &&
         (result_pending(rs_f, ex_reg_write_in, ex_write_reg_in, mem_reg_write_in, mem_write_reg_in) ||
          result_pending(rt_f, ex_reg_write_in, ex_write_reg_in, mem_reg_write_in, mem_write_reg_in))) ||
        (is_jr &&
         result_pending(rs_f, ex_reg_write_in, ex_write_reg_in, mem_reg_write_in, mem_write_reg_in));

    assign stall = load_use || branch_hazard;
    assign taken = is_jump || is_jr || (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);

    assign target = is_jr   ? rs_val :
                    is_jump ? {pc_plus_4_p0[31:28], instr_p0[25:0], 2'b00} :
                              pc_plus_4_p0 + $unsigned(br_off);

    assign fetch.pc_write_out  = !stall;
    assign fetch.pc_src_out    = taken && !stall;
    assign fetch.pc_branch_out = target;

`ifdef ID_DELAY_SLOT_EN
    assign link_val = link ? pc_plus_4_p0 + 32'd4 : pc_plus_4_p0;
`else
    assign link_val = pc_plus_4_p0;
`endif

    // Register file: reset image, then WB writes (never to $0)
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= (i == 0) ? 32'h0 : RESET_REG_VAL;
        end else if (wb_reg_write_in && wb_write_reg_in != 5'd0) begin
            gpr[wb_write_reg_in] <= wb_write_data_in;
        end
    end

    // IF/ID register: hold on stall, flush on redirect, otherwise capture fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_p0     <= NOP_INSTR;
            pc_plus_4_p0 <= 32'h0;
        end else if (!stall) begin
`ifdef ID_DELAY_SLOT_EN
            instr_p0     <= fetch.instruction_in;
            pc_plus_4_p0 <= fetch.pc_plus_4_in;
`else
            if (taken) begin
                instr_p0     <= NOP_INSTR;
                pc_plus_4_p0 <= 32'h0;
            end else begin
                instr_p0     <= fetch.instruction_in;
                pc_plus_4_p0 <= fetch.pc_plus_4_in;
            end
`endif
        end
    end

    // ---- ID/EX stage (p1) ----
    // ID/EX register: a stalled instruction goes down as a control bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            rs_data_out   <= 32'h0;
            rt_data_out   <= 32'h0;
            imm_out       <= 32'h0;
            rs_out        <= 5'd0;
            rt_out        <= 5'd0;
            rd_out        <= 5'd0;
            pc_plus_4_out <= 32'h0;
            ctrl_out      <= 10'h0;
        end else begin
            rs_data_out   <= rs_val;
            rt_data_out   <= rt_val;
            imm_out       <= imm_val;
            rs_out        <= rs_f;
            rt_out        <= rt_f;
            rd_out        <= dest;
            pc_plus_4_out <= link_val;
            ctrl_out      <= stall ? 10'h0 : ctrl_val;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference model predicts every cycle's
// redirect/stall outputs and ID/EX contents; a negedge monitor compares.
module tb_id_stage;
    localparam logic [31:0] RST_VAL = 32'h0;
    localparam logic [31:0] NOP     = 32'h0;

    localparam int K_BAD = 0, K_RALU = 1, K_JR = 2, K_ADDI = 3, K_ANDI = 4, K_ORI = 5;
    localparam int K_LUI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9, K_BNE = 10, K_J = 11, K_JAL = 12;

    typedef struct packed {
        logic [31:0] rs_d, rt_d, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
    } idex_t;

    typedef struct packed {
        idex_t       idex;
        logic        src;
        logic [31:0] br;
        logic        pw;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        exw, exm, memw, wbw;
    logic [4:0]  exr, memr, wbr;
    logic [31:0] wbd;
    logic [31:0] rs_data_out, rt_data_out, imm_out, pc_plus_4_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [9:0]  ctrl_out;

    id_stage_if fif();

    id_stage #(.RESET_REG_VAL(RST_VAL), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .fetch(fif),
        .ex_reg_write_in(exw), .ex_mem_read_in(exm), .ex_write_reg_in(exr),
        .mem_reg_write_in(memw), .mem_write_reg_in(memr),
        .wb_reg_write_in(wbw), .wb_write_reg_in(wbr), .wb_write_data_in(wbd),
        .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .pc_plus_4_out(pc_plus_4_out), .ctrl_out(ctrl_out)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    // Reference model state
    logic [31:0] m_ins, m_pc4;
    logic [31:0] m_gpr [32];
    idex_t       m_idex;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("pc_write", 32'(fif.pc_write_out), 32'(mon_e.pw));
            chk("pc_src", 32'(fif.pc_src_out), 32'(mon_e.src));
            if (mon_e.src) chk("pc_branch", fif.pc_branch_out, mon_e.br);
            chk("rs_data", rs_data_out, mon_e.idex.rs_d);
            chk("rt_data", rt_data_out, mon_e.idex.rt_d);
            chk("imm", imm_out, mon_e.idex.imm);
            chk("pc4_out", pc_plus_4_out, mon_e.idex.pc4);
            chk("rs_idx", 32'(rs_out), 32'(mon_e.idex.rs));
            chk("rt_idx", 32'(rt_out), 32'(mon_e.idex.rt));
            chk("rd_idx", 32'(rd_out), 32'(mon_e.idex.rd));
            chk("ctrl", 32'(ctrl_out), 32'(mon_e.idex.ctrl));
        end
    end

    function automatic int kind_of(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                       6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: return K_RALU;
                       6'h08:   return K_JR;
                       default: return K_BAD;
                   endcase
            6'h08: return K_ADDI;
            6'h0C: return K_ANDI;
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] ralu_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'd0;  6'h22: return 4'd1;  6'h24: return 4'd2;
            6'h25: return 4'd3;  6'h2A: return 4'd4;  6'h00: return 4'd5;
            6'h02: return 4'd6;  default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wbw && wbr == r) return wbd;
        return m_gpr[r];
    endfunction

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && ((exw && exr == r) || (memw && memr == r));
    endfunction

    task automatic model_reset();
        m_ins  = NOP;
        m_pc4  = 32'h0;
        m_idex = '0;
        for (int i = 0; i < 32; i++) m_gpr[i] = (i == 0) ? 32'h0 : RST_VAL;
    endtask

    // One clock: predict this cycle, let the edge happen, advance the model.
    task automatic step();
        int k;
        logic [4:0] rs, rt, dst;
        logic [31:0] rsv, rtv, imm, tgt, pc4o;
        logic signed [31:0] off;
        logic [3:0] aop;
        logic [9:0] ctrl;
        bit rts, lu, stall, taken;
        exp_t e;
        k   = kind_of(m_ins);
        rs  = m_ins[25:21];
        rt  = m_ins[20:16];
        rsv = rdreg(rs);
        rtv = rdreg(rt);
        if (k inside {K_ANDI, K_ORI})  imm = {16'h0, m_ins[15:0]};
        else if (k == K_LUI)           imm = {m_ins[15:0], 16'h0};
        else                           imm = {{16{m_ins[15]}}, m_ins[15:0]};
        if (k == K_RALU)                                  aop = ralu_op(m_ins[5:0]);
        else if (k == K_ANDI)                             aop = 4'd2;
        else if (k == K_ORI)                              aop = 4'd3;
        else if (k == K_LUI)                              aop = 4'd7;
        else if (k inside {K_BEQ, K_BNE})                 aop = 4'd1;
        else                                              aop = 4'd0;
        ctrl = {(k inside {K_RALU, K_ADDI, K_ANDI, K_ORI, K_LUI, K_LW, K_JAL}),
                (k == K_LW), (k == K_SW), (k == K_LW),
                (k inside {K_ADDI, K_ANDI, K_ORI, K_LUI, K_LW, K_SW}),
                (k == K_JAL), aop};
        if (k == K_RALU)                                       dst = m_ins[15:11];
        else if (k inside {K_ADDI, K_ANDI, K_ORI, K_LUI, K_LW}) dst = rt;
        else if (k == K_JAL)                                   dst = 5'd31;
        else                                                   dst = 5'd0;
        rts   = (m_ins[31:26] == 6'h00 && m_ins[5:0] != 6'h08) || (k inside {K_SW, K_BEQ, K_BNE});
        lu    = exm && exr != 5'd0 && (exr == rs || (rts && exr == rt));
        stall = lu || ((k inside {K_BEQ, K_BNE}) && (pend(rs) || pend(rt))) || (k == K_JR && pend(rs));
        taken = (k inside {K_J, K_JAL, K_JR}) || (k == K_BEQ && rsv == rtv) || (k == K_BNE && rsv != rtv);
        off   = $signed(m_ins[15:0]);
        if (k == K_JR)                    tgt = rsv;
        else if (k inside {K_J, K_JAL})   tgt = {m_pc4[31:28], m_ins[25:0], 2'b00};
        else                              tgt = m_pc4 + off * 4;
`ifdef ID_DELAY_SLOT_EN
        pc4o = (k == K_JAL) ? m_pc4 + 32'd4 : m_pc4;
`else
        pc4o = m_pc4;
`endif
        e.idex = m_idex;
        e.src  = taken && !stall;
        e.br   = tgt;
        e.pw   = !stall;
        q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            m_idex = '{rs_d: rsv, rt_d: rtv, imm: imm, pc4: pc4o, rs: rs, rt: rt, rd: dst,
                       ctrl: stall ? 10'h0 : ctrl};
            if (wbw && wbr != 5'd0) m_gpr[wbr] = wbd;
            if (!stall) begin
`ifdef ID_DELAY_SLOT_EN
                m_ins = fif.instruction_in;
                m_pc4 = fif.pc_plus_4_in;
`else
                m_ins = taken ? NOP : fif.instruction_in;
                m_pc4 = taken ? 32'h0 : fif.pc_plus_4_in;
`endif
            end
        end
        #1;
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] pc4);
        fif.instruction_in = ins;
        fif.pc_plus_4_in   = pc4;
        exw = 1'b0; exm = 1'b0; exr = 5'd0;
        memw = 1'b0; memr = 5'd0;
        wbw = 1'b0; wbr = 5'd0; wbd = 32'h0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wbw = 1'b1; wbr = r; wbd = d;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] fn;
        case ($urandom_range(0, 8))
            0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;  3: fn = 6'h25;
            4: fn = 6'h2A;  5: fn = 6'h00;  6: fn = 6'h02;  7: fn = 6'h08;
            default: fn = 6'($urandom);
        endcase
        case ($urandom_range(0, 13))
            0, 1, 2: return {6'h00, pick(), pick(), pick(), 5'($urandom), fn};
            3:  return {6'h08, pick(), pick(), 16'($urandom)};
            4:  return {6'h0C, pick(), pick(), 16'($urandom)};
            5:  return {6'h0D, pick(), pick(), 16'($urandom)};
            6:  return {6'h0F, 5'd0, pick(), 16'($urandom)};
            7:  return {6'h23, pick(), pick(), 16'($urandom)};
            8:  return {6'h2B, pick(), pick(), 16'($urandom)};
            9:  return {6'h04, pick(), pick(), 16'($urandom)};
            10: return {6'h05, pick(), pick(), 16'($urandom)};
            11: return {6'h02, 26'($urandom)};
            12: return {6'h03, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drv(NOP, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, then r5 reads 0 through addi r6,r5,7
        step();
        reset = 1'b1;
        drv(32'h20A6_0007, 32'h4);  step();
        drv(NOP, 32'h8);            step();
        drv(NOP, 32'hC);            step();

        // WB bypass: r8 <= 0x1234 while ID holds addi r9,r8,1
        drv(32'h2109_0001, 32'h10); step();
        drv(NOP, 32'h14); wb(5'd8, 32'h1234); step();
        drv(NOP, 32'h18);           step();

        // load-use: lw r8 in EX, add r10,r8,r9 in ID
        drv(32'h0109_5020, 32'h20); step();
        drv(NOP, 32'h24); exm = 1'b1; exw = 1'b1; exr = 5'd8; step();
        drv(NOP, 32'h24);           step();
        drv(NOP, 32'h28);           step();

        // beq r1,r2,+3 with r1 = r2 = 5
        drv(NOP, 32'h0); wb(5'd1, 32'd5); step();
        drv(NOP, 32'h0); wb(5'd2, 32'd5); step();
        drv(32'h1022_0003, 32'h104); step();
        drv(32'h2003_0001, 32'h108); step();
        drv(NOP, 32'h110);           step();
        drv(NOP, 32'h114);           step();

        // jr r31 with EX still writing r31
        drv(NOP, 32'h0); wb(5'd31, 32'h200); step();
        drv(32'h03E0_0008, 32'h300); step();
        drv(NOP, 32'h304); exw = 1'b1; exr = 5'd31; step();
        drv(NOP, 32'h304);           step();
        drv(NOP, 32'h200);           step();

        // writes to r0 are dropped and never bypassed
        drv(32'h2001_0000, 32'h400); step();
        drv(NOP, 32'h404); wb(5'd0, 32'hFFFF); step();
        drv(NOP, 32'h408);           step();
        drv(NOP, 32'h40C);           step();

        // randomized traffic with occasional reset
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 79) != 0);
            drv(rnd_instr(), $urandom & 32'hFFFF_FFFC);
            exw  = ($urandom_range(0, 3) == 0);
            exm  = exw && ($urandom_range(0, 1) == 1);
            exr  = pick();
            memw = ($urandom_range(0, 3) == 0);
            memr = pick();
            wbw  = ($urandom_range(0, 1) == 1);
            wbr  = pick();
            wbd  = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
            step();
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
